// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and per-channel state type for clk_div_multi
package clk_div_pkg;
  localparam int MAX_CH = 16;
  localparam int CH_IDX_W = 4;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_HALF = 5_000_000;
  typedef struct packed {
    logic [DEF_CNT_W-1:0] cnt;
    logic                 level;
    logic [DEF_CNT_W-1:0] act_half;
    logic [DEF_CNT_W-1:0] pend_half;
    logic                 pend_valid;
  } ch_state_t;
endpackage

// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: control inputs and divided outputs of clk_div_multi
interface clk_div_multi_if import clk_div_pkg::*; #(
  parameter int CH = 2,
  parameter int CNT_W = DEF_CNT_W
) ();
  logic [CH-1:0]       i_en;
  logic                i_sync;
  logic                i_load;
  logic [CH_IDX_W-1:0] i_load_ch;
  logic [CNT_W-1:0]    i_load_half;
  logic [CH-1:0]       o_level;
  logic [CH-1:0]       o_tick;
  logic [CH-1:0]       o_rise;
  logic [CH-1:0]       o_pending;
  modport master (
    output i_en, i_sync, i_load, i_load_ch, i_load_half,
    input  o_level, o_tick, o_rise, o_pending
  );
  modport slave (
    input  i_en, i_sync, i_load, i_load_ch, i_load_half,
    output o_level, o_tick, o_rise, o_pending
  );
endinterface

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel with shadow half-period and registered strobes
module clk_div_channel #(
  parameter int CNT_W = 32,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = '0
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_half,
  output logic             o_level,
  output logic             o_tick,
  output logic             o_rise,
  output logic             o_pending
);
  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic [CNT_W-1:0] act_half;
    logic [CNT_W-1:0] pend_half;
    logic             pend_valid;
  } st_t;
  st_t st_q, st_d;
  logic tick_q, tick_d, rise_q, rise_d;
  logic idle, bnd, apply;
  logic [CNT_W-1:0] nxt_half;
  assign idle = st_q.act_half == '0;
  assign bnd = i_en && !idle && st_q.cnt == st_q.act_half - CNT_W'(1);
  assign apply = st_q.pend_valid && (i_sync || bnd || idle || !i_en);
  assign nxt_half = apply ? st_q.pend_half : st_q.act_half;
  always_comb begin
    st_d = st_q;
    tick_d = 1'b0;
    rise_d = 1'b0;
    if (i_sync) begin
      st_d.cnt = '0;
      st_d.level = 1'b0;
    end else if (bnd) begin
      st_d.cnt = '0;
      st_d.level = nxt_half != '0 && !st_q.level;
      tick_d = st_d.level != st_q.level;
      rise_d = st_d.level;
    end else if (apply) begin
      st_d.cnt = '0;
    end else if (i_en && !idle) begin
      st_d.cnt = st_q.cnt + CNT_W'(1);
    end
    st_d.act_half = nxt_half;
    st_d.pend_valid = i_load || (st_q.pend_valid && !apply);
    st_d.pend_half = i_load ? i_load_half : st_q.pend_half;
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      st_q <= '{cnt: '0, level: 1'b0, act_half: DEFAULT_HALF, pend_half: '0, pend_valid: 1'b0};
      tick_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      st_q <= st_d;
      tick_q <= tick_d;
      rise_q <= rise_d;
    end
  end
  assign o_level = st_q.level;
  assign o_tick = tick_q;
  assign o_rise = rise_q;
  assign o_pending = st_q.pend_valid;
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: CH independent runtime-programmable clock-enable dividers
module clk_div_multi import clk_div_pkg::*; #(
  parameter int CH = 2,
  parameter int CNT_W = DEF_CNT_W,
  parameter int unsigned DEFAULT_HALF = DEF_HALF
) (
  input logic i_clk,
  input logic i_reset_n,
  clk_div_multi_if.slave bus
);
  logic [CH-1:0] level, tick, rise, pending;
  for (genvar g = 0; g < CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W(CNT_W),
      .DEFAULT_HALF(CNT_W'(DEFAULT_HALF))
    ) u_ch (
      .i_clk(i_clk),
      .i_reset_n(i_reset_n),
      .i_en(bus.i_en[g]),
      .i_sync(bus.i_sync),
      .i_load(bus.i_load && bus.i_load_ch == CH_IDX_W'(g)),
      .i_load_half(bus.i_load_half),
      .o_level(level[g]),
      .o_tick(tick[g]),
      .o_rise(rise[g]),
      .o_pending(pending[g])
    );
  end
  assign bus.o_level = level;
  assign bus.o_tick = tick;
  assign bus.o_rise = rise;
  assign bus.o_pending = pending;
endmodule
